// File: rtl/nn_param_loader_pkg.sv
// Shared constants, region encoding and write-bus payload for the parameter loader.
package nn_param_loader_pkg;

   localparam int unsigned DW        = 16;
   localparam int unsigned AW        = 9;
   localparam int unsigned NUM_BANKS = 6;

   localparam int unsigned N_W1 = 224;
   localparam int unsigned N_B1 = 32;
   localparam int unsigned N_W2 = 512;
   localparam int unsigned N_B2 = 16;
   localparam int unsigned N_W3 = 64;
   localparam int unsigned N_B3 = 4;

   // Global stream offset of the first word of each region.
   localparam int unsigned OFF_W1      = 0;
   localparam int unsigned OFF_B1      = OFF_W1 + N_W1;
   localparam int unsigned OFF_W2      = OFF_B1 + N_B1;
   localparam int unsigned OFF_B2      = OFF_W2 + N_W2;
   localparam int unsigned OFF_W3      = OFF_B2 + N_B2;
   localparam int unsigned OFF_B3      = OFF_W3 + N_W3;
   localparam int unsigned TOTAL_WORDS = OFF_B3 + N_B3;

   typedef enum logic [2:0] {
      RG_W1 = 3'd0,
      RG_B1 = 3'd1,
      RG_W2 = 3'd2,
      RG_B2 = 3'd3,
      RG_W3 = 3'd4,
      RG_B3 = 3'd5
   } region_e;

   typedef struct packed {
      logic [NUM_BANKS-1:0] sel;
      logic [AW-1:0]        addr;
      logic [DW-1:0]        din;
   } p_wr_t;

   // Bank address of the final word of a region.
   function automatic logic [AW-1:0] region_last_idx(input region_e r);
      case (r)
         RG_W1:   return AW'(OFF_B1 - OFF_W1 - 1);
         RG_B1:   return AW'(OFF_W2 - OFF_B1 - 1);
         RG_W2:   return AW'(OFF_B2 - OFF_W2 - 1);
         RG_B2:   return AW'(OFF_W3 - OFF_B2 - 1);
         RG_W3:   return AW'(OFF_B3 - OFF_W3 - 1);
         default: return AW'(TOTAL_WORDS - OFF_B3 - 1);
      endcase
   endfunction

   function automatic logic [NUM_BANKS-1:0] region_sel(input region_e r);
      return NUM_BANKS'(1) << r;
   endfunction

endpackage

// File: rtl/nn_param_addr_gen.sv
// Region/index counters walking the parameter stream W1..B3.
module nn_param_addr_gen
   import nn_param_loader_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear_i,
   input  logic          adv_i,
   output logic [2:0]    region_o,
   output logic [AW-1:0] index_o,
   output logic          last_region_c_o,
   output logic          last_all_c_o
);

   region_e       region_q, region_d;
   logic [AW-1:0] index_q,  index_d;

   assign region_o        = region_q;
   assign index_o         = index_q;
   assign last_region_c_o = (index_q == region_last_idx(region_q));
   assign last_all_c_o    = last_region_c_o && (region_q == RG_B3);

   always_comb begin
      region_d = region_q;
      index_d  = index_q;
      if (clear_i) begin
         region_d = RG_W1;
         index_d  = '0;
      end else if (adv_i) begin
         if (last_region_c_o) begin
            index_d  = '0;
            region_d = (region_q == RG_B3) ? RG_W1 : region_e'(region_q + 3'd1);
         end else begin
            index_d = index_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         region_q <= RG_W1;
         index_q  <= '0;
      end else begin
         region_q <= region_d;
         index_q  <= index_d;
      end
   end

endmodule

// File: rtl/nn_param_loader.sv
// Streams host words into the six parameter SRAMs over one shared registered write bus.
module nn_param_loader
   import nn_param_loader_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load_start,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [DW-1:0]        s_data,
   input  logic                 s_last,
   output logic [NUM_BANKS-1:0] p_sel,
   output logic                 p_we,
   output logic [AW-1:0]        p_addr,
   output logic [DW-1:0]        p_din,
   output logic                 busy,
   output logic                 load_done,
   output logic                 load_err,
   output logic [DW-1:0]        checksum
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   p_wr_t         wr_q,    wr_d;
   logic          we_q,    we_d;
   logic          busy_q,  busy_d;
   logic          done_q,  done_d;
   logic          err_q,   err_d;
   logic [DW-1:0] csum_q,  csum_d;

   logic          accept_c;
   logic          clear_c;
   logic [2:0]    region_raw;
   logic [AW-1:0] index;
   logic          last_region;
   logic          last_all;

   nn_param_addr_gen u_addr_gen (
      .clk             (clk),
      .rst_n           (rst_n),
      .clear_i         (clear_c),
      .adv_i           (accept_c),
      .region_o        (region_raw),
      .index_o         (index),
      .last_region_c_o (last_region),
      .last_all_c_o    (last_all)
   );

   // Ready depends on state only so the host may hold valid off it freely.
   assign s_ready  = (state_q == ST_LOAD);
   assign accept_c = s_valid & s_ready;

   always_comb begin
      state_d = state_q;
      wr_d    = '0;
      we_d    = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
      csum_d  = csum_q;
      clear_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (load_start) begin
               state_d = ST_LOAD;
               clear_c = 1'b1;
               csum_d  = '0;
               err_d   = 1'b0;
            end
         end
         ST_LOAD: begin
            if (accept_c) begin
               wr_d.sel  = region_sel(region_e'(region_raw));
               wr_d.addr = index;
               wr_d.din  = s_data;
               we_d      = 1'b1;
               csum_d    = csum_q + s_data;
               // Clean end is s_last exactly on the final word; any mismatch is a framing error.
               if (last_all || s_last) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  err_d   = last_all ^ s_last;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_LOAD) | we_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         wr_q    <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         csum_q  <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         csum_q  <= csum_d;
      end
   end

   assign p_sel     = wr_q.sel;
   assign p_addr    = wr_q.addr;
   assign p_din     = wr_q.din;
   assign p_we      = we_q;
   assign busy      = busy_q;
   assign load_done = done_q;
   assign load_err  = err_q;
   assign checksum  = csum_q;

endmodule

// File: tb/tb_nn_param_loader.sv
// Directed-plus-random bench for nn_param_loader against a stream-offset reference model.
module tb_nn_param_loader;

   logic        clk;
   logic        rst_n;
   logic        load_start;
   logic        s_valid;
   logic        s_ready;
   logic [15:0] s_data;
   logic        s_last;
   logic [5:0]  p_sel;
   logic        p_we;
   logic [8:0]  p_addr;
   logic [15:0] p_din;
   logic        busy;
   logic        load_done;
   logic        load_err;
   logic [15:0] checksum;

   int checks   = 0;
   int failures = 0;

   // Region start offsets in the global stream, plus the total as a sentinel.
   int off [7] = '{0, 224, 256, 768, 784, 848, 852};

   nn_param_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_start (load_start),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .p_sel      (p_sel),
      .p_we       (p_we),
      .p_addr     (p_addr),
      .p_din      (p_din),
      .busy       (busy),
      .load_done  (load_done),
      .load_err   (load_err),
      .checksum   (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int bank_of(input int g);
      for (int b = 0; b < 6; b++)
         if (g >= off[b] && g < off[b+1]) return b;
      return -1;
   endfunction

   task automatic check_zero(input string tag);
      chk({tag, "_ready"}, 32'(s_ready), 0);
      chk({tag, "_sel"},   32'(p_sel), 0);
      chk({tag, "_we"},    32'(p_we), 0);
      chk({tag, "_addr"},  32'(p_addr), 0);
      chk({tag, "_din"},   32'(p_din), 0);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_done"},  32'(load_done), 0);
      chk({tag, "_err"},   32'(load_err), 0);
      chk({tag, "_csum"},  32'(checksum), 0);
   endtask

   // vmode: 0 valid held high, 1 valid toggling, 2 random gaps.
   task automatic do_load(input int last_at, input int vmode, input bit seqd,
                          input int start_at, input int reset_at);
      int          g       = 0;
      int          cyc     = 0;
      int          b;
      bit          fin     = 1'b0;
      bit          acc;
      bit          term;
      bit          exp_err = 1'b0;
      logic [15:0] sum     = '0;
      logic [15:0] d;

      @(negedge clk);
      load_start = 1'b1;
      s_valid    = 1'b0;
      @(negedge clk);
      load_start = 1'b0;
      chk("start_ready",   32'(s_ready), 1);
      chk("start_busy",    32'(busy), 1);
      chk("start_err_clr", 32'(load_err), 0);
      chk("start_csum",    32'(checksum), 0);

      while (!fin && cyc < 4000) begin
         cyc++;
         case (vmode)
            0:       s_valid = 1'b1;
            1:       s_valid = (cyc % 2) == 1;
            default: s_valid = ($urandom_range(0, 3) != 0);
         endcase
         d          = seqd ? 16'(g) : 16'($urandom);
         s_data     = d;
         s_last     = (g == last_at);
         load_start = (g == start_at) && s_valid;
         acc        = s_valid && s_ready;
         @(posedge clk);
         #1;
         load_start = 1'b0;
         if (acc) begin
            b    = bank_of(g);
            sum  = sum + d;
            term = (g == 851) || (g == last_at);
            chk("wr_we",   32'(p_we), 1);
            chk("wr_sel",  32'(p_sel), 32'(6'(1) << b));
            chk("wr_addr", 32'(p_addr), 32'(g - off[b]));
            chk("wr_din",  32'(p_din), 32'(d));
            chk("wr_busy", 32'(busy), 1);
            chk("wr_done", 32'(load_done), 32'(term));
            if (term) begin
               exp_err = !(g == 851 && last_at == 851);
               chk("end_err",  32'(load_err), 32'(exp_err));
               chk("end_csum", 32'(checksum), 32'(sum));
               fin = 1'b1;
            end
            g++;
         end else begin
            chk("gap_we",   32'(p_we), 0);
            chk("gap_sel",  32'(p_sel), 0);
            chk("gap_done", 32'(load_done), 0);
         end
         if (!fin && reset_at >= 0 && g == reset_at) begin
            #2 rst_n = 1'b0;
            #1 check_zero("rst_mid");
            @(negedge clk);
            rst_n   = 1'b1;
            s_valid = 1'b0;
            s_last  = 1'b0;
            return;
         end
         @(negedge clk);
      end
      if (!fin) chk("timeout", 0, 1);
      s_valid = 1'b0;
      s_last  = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_ready", 32'(s_ready), 0);
      chk("idle_busy",  32'(busy), 0);
      chk("idle_we",    32'(p_we), 0);
      chk("idle_done",  32'(load_done), 0);
      chk("idle_err",   32'(load_err), 32'(exp_err));
      chk("idle_csum",  32'(checksum), 32'(sum));
   endtask

   initial begin
      rst_n      = 1'b0;
      load_start = 1'b0;
      s_valid    = 1'b0;
      s_data     = '0;
      s_last     = 1'b0;
      #12;
      check_zero("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("rst_rel");

      // Full sequential load, valid held high.
      do_load(851, 0, 1'b1, -1, -1);
      chk("csum_full", 32'(checksum), 32'h881E);

      // Same stream with valid toggling.
      do_load(851, 1, 1'b1, -1, -1);

      // Early s_last on word 100.
      do_load(100, 2, 1'b0, -1, -1);

      // Final word without s_last, then a clean random load clears the error.
      do_load(-1, 0, 1'b1, -1, -1);
      do_load(851, 2, 1'b0, -1, -1);

      // Reset after 300 accepts, then a full reload.
      do_load(851, 0, 1'b1, -1, 300);
      do_load(851, 0, 1'b1, -1, -1);
      chk("csum_reload", 32'(checksum), 32'h881E);

      // Stray load_start mid-load is ignored.
      do_load(851, 0, 1'b1, 50, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
